funcq_issuer: RTL
=================

Name: funcq_issuer

Overview:
Initiator-side front end for the funcQ engine. It buffers operand tuples {a,b,c,d} arriving on a valid/ready stream and issues them one at a time to funcQ as a single-cycle data_vld pulse. It waits for Q_vld, with a timeout, and returns each tagged result on a valid/ready result stream. It sits between the system operand source and the funcQ instance, and owns the only driver of funcQ's input pins.

Parameters:
DATA_WIDTH, 16, signed width of a, b, c, d and Q
FIFO_DEPTH, 4, operand FIFO entries (power of 2, >=2)
TIMEOUT, 64, max WAIT cycles for Q_vld before a timeout result (>=2)
TAG_WIDTH, 4, request tag width; tag wraps modulo 2^TAG_WIDTH

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low
in_vld  in  1  operand tuple valid
in_rdy  out  1  FIFO can accept a tuple
in_a, in_b, in_c, in_d  in  DATA_WIDTH each  signed operands
data_vld  out  1  issue pulse to funcQ
a, b, c, d  out  DATA_WIDTH each  operands to funcQ
Q_vld  in  1  result valid from funcQ
Q  in  DATA_WIDTH  result from funcQ
res_vld  out  1  result available
res_rdy  in  1  consumer accepts result
res_q  out  DATA_WIDTH  captured Q (0 on timeout)
res_tag  out  TAG_WIDTH  tag of the request
res_timeout  out  1  result is a timeout
err_stray  out  1  sticky: Q_vld seen outside WAIT
busy  out  1  state != IDLE or FIFO non-empty

Behaviour:
- Reset (rst=0, async): FIFO empty, state IDLE, tag=0, timeout counter=0. All outputs are 0, except in_rdy, which is 1 after reset releases.
- in_rdy = !full. The FIFO pushes on in_vld&&in_rdy. A full FIFO keeps in_rdy=0 even if a pop happens in the same cycle (no pass-through).
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE -> ISSUE when the FIFO is non-empty. On that edge: pop the head; load a/b/c/d from the head; register the current tag; increment tag.
- ISSUE (1 cycle): data_vld=1. Always -> WAIT.
- a/b/c/d hold stable from ISSUE until leaving RESP. In all other states a/b/c/d keep their last value.
- WAIT: the counter increments each cycle.
  - Q_vld=1: capture Q into res_q, res_timeout=0, -> RESP.
  - Else, on the cycle the counter reaches TIMEOUT-1: res_q=0, res_timeout=1, -> RESP.
  - If Q_vld arrives on that same final cycle, Q_vld wins (normal result).
- RESP: res_vld=1, and res_q/res_tag/res_timeout are stable. On res_vld&&res_rdy -> IDLE and clear the counter. Back-pressure holds RESP indefinitely; the FIFO keeps accepting meanwhile.
- Latency with an empty FIFO and idle FSM:
  - Handshake at edge k.
  - IDLE->ISSUE at edge k+1; data_vld is high between edges k+1 and k+2.
  - Q_vld sampled at edge m gives res_vld=1 after edge m.
  - Back-to-back throughput: one request per (engine latency + 3) cycles with res_rdy=1.
- Q_vld while in IDLE, ISSUE or RESP is ignored for data and sets err_stray. err_stray clears only on reset.
- A late Q_vld after a timeout is treated as stray.
- Tag wraps from 2^TAG_WIDTH-1 to 0.
- Reset mid-operation: immediate abort. Pending FIFO contents are discarded and no result is produced.

Decomposition:
- Shared package funcq_pkg holds:
  - typedef enum funcq_state_e {IDLE, ISSUE, WAIT, RESP};
  - typedef struct packed funcq_ops_t {a,b,c,d}, parameterised by DATA_WIDTH via a package localparam default of 16;
  - localparam FUNCQ_TIMEOUT_DEF = 64.
- Sub-module funcq_op_fifo: synchronous FIFO of funcq_ops_t with full/empty/level. The issuer holds the FSM, counter, tag and result register.

Test Plan:
- Single request: a=12, b=5, c=-2, d=3; stub engine Q=a+b+c+d with 3-cycle latency. Expect data_vld high for exactly 1 cycle, a..d stable, res_vld with res_q=18, res_tag=0, res_timeout=0.
- Burst: push 6 tuples with res_rdy=1 and FIFO_DEPTH=4. Expect in_rdy low while full, results in order with tags 0..5, and no lost or duplicated tuple.
- Timeout: stub never asserts Q_vld. Expect res_vld after exactly TIMEOUT WAIT cycles, res_timeout=1, res_q=0. A later Q_vld sets err_stray=1.
- Race: Q_vld=1 with Q=-7 on the final WAIT cycle. Expect res_q=-7, res_timeout=0.
- Back-pressure: hold res_rdy=0 for 20 cycles. Expect res_* stable, no new data_vld, and the FIFO fills to 4 with in_rdy=0. Release gives in-order drain.
- Reset mid-WAIT: drop rst with 3 tuples queued. Expect all outputs 0 immediately, tag restarts at 0, and no result emitted after reset release.

Source files
------------

// File: rtl/funcq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : funcq_pkg
// Description : Shared types and defaults for the funcQ issuer front end.
//               FSM state encoding, operand tuple struct and default timing.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package funcq_pkg;

  localparam int FUNCQ_DATA_WIDTH_DEF = 16;
  localparam int FUNCQ_TIMEOUT_DEF    = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } funcq_state_e;

  // Operand tuple at the default data width; the issuer declares its own
  // copy sized by its DATA_WIDTH parameter and hands it to the FIFO.
  typedef struct packed {
    logic signed [FUNCQ_DATA_WIDTH_DEF-1:0] a;
    logic signed [FUNCQ_DATA_WIDTH_DEF-1:0] b;
    logic signed [FUNCQ_DATA_WIDTH_DEF-1:0] c;
    logic signed [FUNCQ_DATA_WIDTH_DEF-1:0] d;
  } funcq_ops_t;

endpackage
`default_nettype wire

// File: rtl/funcq_op_fifo.sv
`default_nettype none
// ============================================================================
// Module      : funcq_op_fifo
// Description : Synchronous FIFO of operand tuples with full/empty/level.
//               Writes are dropped when full, reads ignored when empty.
// Ports       : clk, rst (async, active-low)
//               push_i/data_i  - write side
//               pop_i/data_o   - read side, data_o shows the head entry
//               full_o, empty_o, level_o - occupancy status
// Revision    : 1.0 - initial release
// ============================================================================
module funcq_op_fifo
  import funcq_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = funcq_ops_t
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  T                       data_i,
  input  logic                   pop_i,
  output T                       data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] level_o
);

  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);

  T              mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   level_q;
  logic          w_push;
  logic          w_pop;

  assign full_o  = (level_q == LVL_FULL);
  assign empty_o = (level_q == '0);
  assign w_push  = push_i && !full_o;
  assign w_pop   = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q];
  assign level_o = level_q;

  // Storage has no reset: contents are only visible through valid pointers.
  always_ff @(posedge clk) begin
    if (w_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (w_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (w_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({w_push, w_pop})
        2'b10:   level_q <= level_q + (AW+1)'(1);
        2'b01:   level_q <= level_q - (AW+1)'(1);
        default: level_q <= level_q;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/funcq_issuer.sv
`default_nettype none
// ============================================================================
// Module      : funcq_issuer
// Description : Initiator front end for the funcQ engine. Buffers operand
//               tuples, issues one at a time as a single-cycle data_vld
//               pulse, waits for Q_vld with a timeout and returns a tagged
//               result on a valid/ready stream.
// Ports       : clk, rst (async, active-low)
//               in_vld/in_rdy/in_a..in_d       - operand stream in
//               data_vld/a..d                  - drive to funcQ
//               Q_vld/Q                        - result from funcQ
//               res_vld/res_rdy/res_q/res_tag/res_timeout - result stream
//               err_stray - sticky, Q_vld seen while not waiting
//               busy      - request in flight or FIFO non-empty
// Revision    : 1.0 - initial release
// ============================================================================
module funcq_issuer
  import funcq_pkg::*;
#(
  parameter int DATA_WIDTH = FUNCQ_DATA_WIDTH_DEF,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = FUNCQ_TIMEOUT_DEF,
  parameter int TAG_WIDTH  = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_vld,
  output logic                         in_rdy,
  input  logic signed [DATA_WIDTH-1:0] in_a,
  input  logic signed [DATA_WIDTH-1:0] in_b,
  input  logic signed [DATA_WIDTH-1:0] in_c,
  input  logic signed [DATA_WIDTH-1:0] in_d,
  output logic                         data_vld,
  output logic signed [DATA_WIDTH-1:0] a,
  output logic signed [DATA_WIDTH-1:0] b,
  output logic signed [DATA_WIDTH-1:0] c,
  output logic signed [DATA_WIDTH-1:0] d,
  input  logic                         Q_vld,
  input  logic signed [DATA_WIDTH-1:0] Q,
  output logic                         res_vld,
  input  logic                         res_rdy,
  output logic signed [DATA_WIDTH-1:0] res_q,
  output logic [TAG_WIDTH-1:0]         res_tag,
  output logic                         res_timeout,
  output logic                         err_stray,
  output logic                         busy
);

  localparam int              CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef struct packed {
    logic signed [DATA_WIDTH-1:0] a;
    logic signed [DATA_WIDTH-1:0] b;
    logic signed [DATA_WIDTH-1:0] c;
    logic signed [DATA_WIDTH-1:0] d;
  } ops_t;

  funcq_state_e                 state_q;
  logic [TAG_WIDTH-1:0]         tag_q;
  logic [TAG_WIDTH-1:0]         req_tag_q;
  logic [CNT_W-1:0]             cnt_q;
  logic                         data_vld_q;
  ops_t                         ops_q;
  logic                         res_vld_q;
  logic signed [DATA_WIDTH-1:0] res_q_q;
  logic [TAG_WIDTH-1:0]         res_tag_q;
  logic                         res_timeout_q;
  logic                         err_stray_q;

  ops_t                         w_in_ops;
  ops_t                         w_head;
  logic                         w_full;
  logic                         w_empty;
  logic                         w_pop;
  logic [$clog2(FIFO_DEPTH):0]  w_level;

  assign w_in_ops = {in_a, in_b, in_c, in_d};
  // Pop only from IDLE; the head is consumed on the same edge as IDLE->ISSUE.
  assign w_pop    = (state_q == IDLE);

  funcq_op_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (ops_t)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (in_vld),
    .data_i  (w_in_ops),
    .pop_i   (w_pop),
    .data_o  (w_head),
    .full_o  (w_full),
    .empty_o (w_empty),
    .level_o (w_level)
  );

  // No pass-through: a full FIFO stays not-ready even if it pops this cycle.
  assign in_rdy = !w_full;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      tag_q         <= '0;
      req_tag_q     <= '0;
      cnt_q         <= '0;
      data_vld_q    <= 1'b0;
      ops_q         <= '0;
      res_vld_q     <= 1'b0;
      res_q_q       <= '0;
      res_tag_q     <= '0;
      res_timeout_q <= 1'b0;
      err_stray_q   <= 1'b0;
    end else begin
      data_vld_q <= 1'b0;
      // Any Q_vld outside WAIT (including a late one after a timeout) is stray.
      if (Q_vld && (state_q != WAIT)) begin
        err_stray_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (!w_empty) begin
            state_q    <= ISSUE;
            data_vld_q <= 1'b1;
            ops_q      <= w_head;
            req_tag_q  <= tag_q;
            tag_q      <= tag_q + TAG_WIDTH'(1);
          end
        end
        ISSUE: begin
          state_q <= WAIT;
        end
        WAIT: begin
          // Q_vld is tested first so it wins on the final counted cycle.
          if (Q_vld) begin
            state_q       <= RESP;
            res_vld_q     <= 1'b1;
            res_q_q       <= Q;
            res_tag_q     <= req_tag_q;
            res_timeout_q <= 1'b0;
          end else if (cnt_q == CNT_LAST) begin
            state_q       <= RESP;
            res_vld_q     <= 1'b1;
            res_q_q       <= '0;
            res_tag_q     <= req_tag_q;
            res_timeout_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        RESP: begin
          if (res_rdy) begin
            state_q   <= IDLE;
            res_vld_q <= 1'b0;
            cnt_q     <= '0;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign data_vld    = data_vld_q;
  assign a           = ops_q.a;
  assign b           = ops_q.b;
  assign c           = ops_q.c;
  assign d           = ops_q.d;
  assign res_vld     = res_vld_q;
  assign res_q       = res_q_q;
  assign res_tag     = res_tag_q;
  assign res_timeout = res_timeout_q;
  assign err_stray   = err_stray_q;
  assign busy        = (state_q != IDLE) || (w_level != '0);

endmodule
`default_nettype wire
